window_slide_sched: RTL and testbench
=====================================

# window_slide_sched

Controller that sequences one `window_slide` instance per binary image frame. It buffers an upstream bit stream that may stall, then replays the frame into `window_slide` without gaps. It issues `slide` requests and hands each K×K window to a downstream consumer over a valid/ready handshake. The block sits between the image source and the binary-kernel compute stage.

## Interface
- IMAGE_ROW_LEN, 10: image is square, IMAGE_ROW_LEN×IMAGE_ROW_LEN bits; IMAGE_SIZE = IMAGE_ROW_LEN².
- KERNEL_SIZE, 3: window edge; window width KK = KERNEL_SIZE².
- STRIDE, 1: slide step; WPR = (IMAGE_ROW_LEN−KERNEL_SIZE)/STRIDE+1 windows per row; NUM_WIN = WPR².
- TIMEOUT, 1024: watchdog limit in cycles; used only with the watchdog macro.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pix_valid  in  1  upstream bit valid.
- pix_data  in  1  upstream image bit, row-major.
- pix_ready  out  1  high only in FILL.
- ws_new_image  out  1  high with the first streamed bit.
- ws_x_in  out  1  streamed bit to `window_slide`.
- ws_slide  out  1  one-cycle slide request.
- ws_y_out  in  KK  window from `window_slide`; bit r·K+c is window pixel (r,c).
- ws_valid  in  1  `ws_y_out` valid.
- win_valid  out  1  window presented downstream.
- win_data  out  KK  registered copy of `ws_y_out`.
- win_row, win_col  out  $clog2(WPR) (min 1)  window index in stride units.
- win_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last window is accepted.
- err  out  1  sticky watchdog flag; tied 0 without the watchdog macro.

## Operation
- States: IDLE, FILL, STREAM, WAIT_WIN, PRESENT, SLIDE, DONE.
- IDLE: on `start`, clear the counters and go to FILL. `start` in any other state is ignored.
- FILL: `pix_ready`=1. Each `pix_valid` handshake writes `buf[wptr++]`.
  - When the bit at IMAGE_SIZE−1 is written, go to STREAM.
  - Gaps in `pix_valid` are allowed.
- STREAM: for IMAGE_SIZE consecutive cycles, `ws_x_in`=`buf[rptr++]`.
  - `ws_new_image`=1 only when rptr=0.
  - After the last bit, go to WAIT_WIN.
- WAIT_WIN: on `ws_valid`, capture `ws_y_out` into `win_data` and go to PRESENT.
  - `ws_valid` in any other state is ignored.
- PRESENT: `win_valid`=1 and `win_data` is held stable until `win_ready`.
  - On handshake with win_cnt < NUM_WIN−1: increment `win_col`; wrap at WPR−1 to 0 and increment `win_row`; go to SLIDE.
  - On handshake with the last window: go to DONE.
- SLIDE: `ws_slide`=1 for exactly one cycle, then go to WAIT_WIN.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- Window 0 needs no slide. Exactly NUM_WIN−1 slides are issued per frame.

## Timing
- Reset values: state=IDLE and all counters 0. All outputs are 0, including `win_data`. Buffer contents are undefined.
- Reset mid-frame aborts immediately. The next frame must restart with `start`.
- All outputs are registered; no combinational path from any input to any output.
- `start` sampled at edge n: `pix_ready`=1 from cycle n+1.
- Last FILL handshake at edge m: `ws_new_image`/`ws_x_in` valid in cycles m+1 … m+IMAGE_SIZE.
- `ws_valid` at edge p: `win_valid`=1 from cycle p+1.
- Window handshake at edge q: `ws_slide`=1 in cycle q+1, then WAIT_WIN from q+2.
- Last window handshake at edge q: `frame_done`=1 in cycle q+1, `busy`=0 from q+2.
- `busy` falls in the same cycle the state returns to IDLE, so `start` is accepted the cycle after `frame_done`.

## Configuration
- `WS_SCHED_WATCHDOG_EN` defined:
  - A counter runs in WAIT_WIN and clears on entry.
  - If it reaches TIMEOUT without `ws_valid`, set `err`=1 (sticky until `rst`), pulse `frame_done`, and return to IDLE.
- `WS_SCHED_WATCHDOG_EN` undefined: no counter, `err` tied 0, and WAIT_WIN waits forever.

## Structure
- Shared package `window_slide_pkg`:
  - state enum `ws_sched_state_e`.
  - constant functions for WPR, NUM_WIN and the index width.
- One sub-module, `ws_bit_buffer`: IMAGE_SIZE×1 storage with a write port and a read port plus full/last-read flags, reset only on pointers.

## Test plan
- Defaults, striped image (even rows 1, odd rows 0), `win_ready` always 1:
  - 64 windows; window 0 `win_data`=9'b111000111; window (row 1, col 0)=9'b000111000.
  - 63 `ws_slide` pulses; one `frame_done`.
- Upstream `pix_valid` toggled 1-0 every cycle:
  - STREAM still emits 100 contiguous bits.
  - `ws_new_image` high exactly once, on bit 0.
- `win_ready` held 0 for 20 cycles on window 5:
  - `win_data`, `win_row`=0 and `win_col`=5 stable throughout.
  - No `ws_slide` until the handshake.
- `start` pulsed in FILL, in PRESENT, and in the same cycle as `frame_done`:
  - All ignored; `start` one cycle after `frame_done` begins a new FILL.
- `rst` asserted during STREAM at bit 40:
  - All outputs 0 immediately; the next `start` runs a full 64-window frame.
- With `WS_SCHED_WATCHDOG_EN` and TIMEOUT=16, `ws_valid` withheld:
  - `err`=1 and `frame_done` pulse 16 cycles after entering WAIT_WIN, then `busy`=0.

Source files
------------

// File: rtl/window_slide_pkg.sv
// Shared state encoding and sizing helpers for the window_slide frame scheduler.
package window_slide_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_WIN = 3'd3,
        ST_PRESENT  = 3'd4,
        ST_SLIDE    = 3'd5,
        ST_DONE     = 3'd6
    } ws_sched_state_e;

    function automatic int calc_wpr(input int row_len, input int kernel, input int stride);
        return (row_len - kernel) / stride + 1;
    endfunction

    function automatic int calc_num_win(input int row_len, input int kernel, input int stride);
        int wpr;
        wpr = calc_wpr(row_len, kernel, stride);
        return wpr * wpr;
    endfunction

    // Index width for a count of n items, never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ws_bit_buffer.sv
// One-bit-wide frame store: write port fed by the upstream fill, read port replays in order.
// Only the pointers are reset; storage contents are don't-care until written.
module ws_bit_buffer #(
    parameter int DEPTH = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic wr_en_i,
    input  logic wr_data_i,
    input  logic rd_en_i,
    output logic rd_data_o,
    output logic wr_last_o,
    output logic rd_first_o,
    output logic rd_last_o
);
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en_i) wptr_d = wptr_q + 1'b1;
            if (rd_en_i) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
    end

    assign rd_data_o  = mem_q[rptr_q];
    assign wr_last_o  = (wptr_q == PTR_LAST);
    assign rd_first_o = (rptr_q == '0);
    assign rd_last_o  = (rptr_q == PTR_LAST);

endmodule

// File: rtl/window_slide_sched.sv
// Buffers one binary frame, replays it gap-free into window_slide, then hands out every window.
// Optional WS_SCHED_WATCHDOG_EN adds a WAIT_WIN timeout that sets a sticky err and ends the frame.
//   state    | meaning
//   IDLE     | waiting for start
//   FILL     | accepting upstream bits into the buffer
//   STREAM   | replaying the buffer, one bit per cycle
//   WAIT_WIN | waiting for window_slide to report a window
//   PRESENT  | window offered downstream until accepted
//   SLIDE    | one-cycle slide request
//   DONE     | one-cycle frame_done pulse
module window_slide_sched
    import window_slide_pkg::*;
#(
    parameter int IMAGE_ROW_LEN = 10,
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int TIMEOUT       = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   pix_valid,
    input  logic                                   pix_data,
    output logic                                   pix_ready,
    output logic                                   ws_new_image,
    output logic                                   ws_x_in,
    output logic                                   ws_slide,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]     ws_y_out,
    input  logic                                   ws_valid,
    output logic                                   win_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]     win_data,
    output logic [calc_idx_w(calc_wpr(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE))-1:0] win_row,
    output logic [calc_idx_w(calc_wpr(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE))-1:0] win_col,
    input  logic                                   win_ready,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   err
);
    localparam int IMAGE_SIZE = IMAGE_ROW_LEN * IMAGE_ROW_LEN;
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WPR        = calc_wpr(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE);
    localparam int NUM_WIN    = calc_num_win(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE);
    localparam int IDX_W      = calc_idx_w(WPR);
    localparam int CNT_W      = calc_idx_w(NUM_WIN);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(WPR - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(NUM_WIN - 1);

    ws_sched_state_e  state_q, state_d;
    logic [IDX_W-1:0] win_row_q, win_row_d;
    logic [IDX_W-1:0] win_col_q, win_col_d;
    logic [CNT_W-1:0] win_left_q, win_left_d;
    logic [KK-1:0]    win_data_q, win_data_d;

    logic buf_clr, buf_wr, buf_rd;
    logic buf_rd_data, buf_wr_last, buf_rd_first, buf_rd_last;

`ifdef WS_SCHED_WATCHDOG_EN
    localparam int WD_W = calc_idx_w(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
`endif

    ws_bit_buffer #(
        .DEPTH (IMAGE_SIZE)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (buf_clr),
        .wr_en_i    (buf_wr),
        .wr_data_i  (pix_data),
        .rd_en_i    (buf_rd),
        .rd_data_o  (buf_rd_data),
        .wr_last_o  (buf_wr_last),
        .rd_first_o (buf_rd_first),
        .rd_last_o  (buf_rd_last)
    );

    always_comb begin
        state_d    = state_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        win_left_d = win_left_q;
        win_data_d = win_data_q;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;
`ifdef WS_SCHED_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FILL;
                    buf_clr    = 1'b1;
                    win_row_d  = '0;
                    win_col_d  = '0;
                    win_left_d = WIN_LOAD;
                end
            end
            ST_FILL: begin
                if (pix_valid) begin
                    buf_wr = 1'b1;
                    if (buf_wr_last) state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                buf_rd = 1'b1;
                if (buf_rd_last) begin
                    state_d = ST_WAIT_WIN;
`ifdef WS_SCHED_WATCHDOG_EN
                    wd_cnt_d = WD_LOAD;
`endif
                end
            end
            ST_WAIT_WIN: begin
                if (ws_valid) begin
                    win_data_d = ws_y_out;
                    state_d    = ST_PRESENT;
                end
`ifdef WS_SCHED_WATCHDOG_EN
                else if (wd_cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q - 1'b1;
                end
`endif
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    if (win_left_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_SLIDE;
                        win_left_d = win_left_q - 1'b1;
                        if (win_col_q == COL_LAST) begin
                            win_col_d = '0;
                            win_row_d = win_row_q + 1'b1;
                        end else begin
                            win_col_d = win_col_q + 1'b1;
                        end
                    end
                end
            end
            ST_SLIDE: begin
                state_d = ST_WAIT_WIN;
`ifdef WS_SCHED_WATCHDOG_EN
                wd_cnt_d = WD_LOAD;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_row_q  <= '0;
            win_col_q  <= '0;
            win_left_q <= '0;
            win_data_q <= '0;
        end else begin
            state_q    <= state_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            win_left_q <= win_left_d;
            win_data_q <= win_data_d;
        end
    end

`ifdef WS_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    // TIMEOUT only sizes the watchdog; without it there is nothing to configure.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end

    assign err = 1'b0;
`endif

    // Every output decodes flopped state only, so no input reaches an output combinationally.
    assign pix_ready    = (state_q == ST_FILL);
    assign ws_x_in      = (state_q == ST_STREAM) && buf_rd_data;
    assign ws_new_image = (state_q == ST_STREAM) && buf_rd_first;
    assign ws_slide     = (state_q == ST_SLIDE);
    assign win_valid    = (state_q == ST_PRESENT);
    assign win_data     = win_data_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_slide_sched.sv
// Directed bench for window_slide_sched; the bench plays window_slide from the image it sent.
// Define WS_SCHED_WATCHDOG_EN to also cover the watchdog path with TIMEOUT=16.
`timescale 1ns/1ps
module tb_window_slide_sched;
    localparam int ROW = 10;
    localparam int K   = 3;
    localparam int KK  = 9;
    localparam int IS  = 100;
    localparam int WPR = 8;
    localparam int NW  = 64;
`ifdef WS_SCHED_WATCHDOG_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_data  = 1'b0;
    logic          ws_valid  = 1'b0;
    logic          win_ready = 1'b1;
    logic [KK-1:0] ws_y_out  = '0;
    logic          pix_ready, ws_new_image, ws_x_in, ws_slide;
    logic          win_valid, busy, frame_done, err;
    logic [KK-1:0] win_data;
    logic [2:0]    win_row, win_col;

    int errors  = 0;
    int checks  = 0;
    int n_slide = 0;
    int n_done  = 0;
    int base_slide, base_done;
    logic [IS-1:0] img_stripe, img_rand, img_rand2;

    always #5 clk = ~clk;

    window_slide_sched #(
        .IMAGE_ROW_LEN (ROW),
        .KERNEL_SIZE   (K),
        .STRIDE        (1),
        .TIMEOUT       (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .ws_new_image (ws_new_image),
        .ws_x_in      (ws_x_in),
        .ws_slide     (ws_slide),
        .ws_y_out     (ws_y_out),
        .ws_valid     (ws_valid),
        .win_valid    (win_valid),
        .win_data     (win_data),
        .win_row      (win_row),
        .win_col      (win_col),
        .win_ready    (win_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .err          (err)
    );

    always @(negedge clk) begin
        if (ws_slide)   n_slide++;
        if (frame_done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [KK-1:0] win_of(input logic [IS-1:0] img, input int r, input int c);
        logic [KK-1:0] w;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[i*K + j] = img[(r + i)*ROW + c + j];
        return w;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_ready"},  pix_ready,    0);
        chk({tag, "_new_image"},  ws_new_image, 0);
        chk({tag, "_x_in"},       ws_x_in,      0);
        chk({tag, "_slide"},      ws_slide,     0);
        chk({tag, "_win_valid"},  win_valid,    0);
        chk({tag, "_win_data"},   win_data,     0);
        chk({tag, "_win_row"},    win_row,      0);
        chk({tag, "_win_col"},    win_col,      0);
        chk({tag, "_busy"},       busy,         0);
        chk({tag, "_frame_done"}, frame_done,   0);
        chk({tag, "_err"},        err,          0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pix_ready_after_start", pix_ready, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic fill(input logic [IS-1:0] img, input bit gap, input bit poke);
        for (int k = 0; k < IS; k++) begin
            if (gap && k > 0) begin
                pix_valid = 1'b0;
                step();
            end
            pix_valid = 1'b1;
            pix_data  = img[k];
            start     = poke && (k == 50);
            step();
            start = 1'b0;
            if (k == 50) chk("pix_ready_mid_fill", pix_ready, 1);
        end
        pix_valid = 1'b0;
        pix_data  = 1'b0;
    endtask

    task automatic stream(input logic [IS-1:0] img, input int stop_at);
        for (int k = 0; k < IS; k++) begin
            chk("ws_x_in", ws_x_in, img[k]);
            chk("ws_new_image", ws_new_image, (k == 0));
            if (k == 0) chk("pix_ready_stream", pix_ready, 0);
            if (k == stop_at) return;
            step();
        end
    endtask

    task automatic windows(input logic [IS-1:0] img, input bit stripes, input bit extras);
        logic [KK-1:0] exp;
        for (int w = 0; w < NW; w++) begin
            exp      = win_of(img, w / WPR, w % WPR);
            ws_valid = 1'b1;
            ws_y_out = exp;
            step();
            ws_valid = 1'b0;
            ws_y_out = '0;
            chk("win_valid", win_valid, 1);
            chk("win_data", win_data, exp);
            chk("win_row", win_row, w / WPR);
            chk("win_col", win_col, w % WPR);
            if (stripes && w == 0)   chk("win0_stripe", win_data, 9'b111000111);
            if (stripes && w == WPR) chk("win_r1c0_stripe", win_data, 9'b000111000);
            if (extras && w == 5) begin
                win_ready = 1'b0;
                for (int h = 0; h < 20; h++) begin
                    step();
                    chk("hold_valid", win_valid, 1);
                    chk("hold_data", win_data, exp);
                    chk("hold_row", win_row, 0);
                    chk("hold_col", win_col, 5);
                    chk("hold_no_slide", ws_slide, 0);
                end
                win_ready = 1'b1;
            end
            if (extras && w == 10) start = 1'b1;
            step();
            start = 1'b0;
            if (w < NW - 1) begin
                chk("ws_slide", ws_slide, 1);
                chk("win_valid_drop", win_valid, 0);
                chk("no_early_done", frame_done, 0);
                if (extras && w == 20) begin
                    ws_valid = 1'b1;
                    ws_y_out = ~exp;
                end
                step();
                ws_valid = 1'b0;
                ws_y_out = '0;
                chk("ws_slide_one_cycle", ws_slide, 0);
            end else begin
                chk("frame_done", frame_done, 1);
                chk("busy_in_done", busy, 1);
                chk("no_slide_last", ws_slide, 0);
            end
        end
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, "_slides"}, n_slide - base_slide, NW - 1);
        chk({tag, "_dones"},  n_done - base_done, 1);
    endtask

    initial begin
        for (int k = 0; k < IS; k++) begin
            img_stripe[k] = ((k / ROW) % 2 == 0);
            img_rand[k]   = 1'($urandom_range(1, 0));
        end
        img_rand2 = ~img_rand;

        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Frame A: striped, stray start pulses, held window 5, start alongside frame_done.
        base_slide = n_slide;
        base_done  = n_done;
        do_start();
        fill(img_stripe, 1'b0, 1'b1);
        stream(img_stripe, IS);
        windows(img_stripe, 1'b1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_with_done_busy", busy, 0);
        chk("start_with_done_ready", pix_ready, 0);
        chk("done_one_cycle", frame_done, 0);
        frame_counts("frameA");

        // Frame B: start the cycle after frame_done, upstream valid toggling.
        base_slide = n_slide;
        base_done  = n_done;
        do_start();
        fill(img_rand, 1'b1, 1'b0);
        stream(img_rand, IS);
        windows(img_rand, 1'b0, 1'b0);
        step();
        chk("frameB_idle", busy, 0);
        frame_counts("frameB");

        // Frame C: reset while streaming bit 40.
        do_start();
        fill(img_stripe, 1'b0, 1'b0);
        stream(img_stripe, 40);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        step();
        rst = 1'b0;
        step();
        chk("after_rst_busy", busy, 0);

        // Frame D: full frame after the abort.
        base_slide = n_slide;
        base_done  = n_done;
        do_start();
        fill(img_rand2, 1'b0, 1'b0);
        stream(img_rand2, IS);
        windows(img_rand2, 1'b0, 1'b0);
        step();
        chk("frameD_idle", busy, 0);
        frame_counts("frameD");

`ifdef WS_SCHED_WATCHDOG_EN
        do_start();
        fill(img_stripe, 1'b0, 1'b0);
        stream(img_stripe, IS);
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            chk("wd_no_done", frame_done, 0);
            chk("wd_no_err", err, 0);
            chk("wd_busy", busy, 1);
            step();
        end
        chk("wd_frame_done", frame_done, 1);
        chk("wd_err", err, 1);
        step();
        chk("wd_idle", busy, 0);
        chk("wd_err_sticky", err, 1);
        chk("wd_done_pulse", frame_done, 0);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
